// File: rtl/aes_pkg.sv
// Shared AES constants and the FSM state encoding for the inverse SubBytes block.
package aes_pkg;

    localparam int AES_STATE_W = 128;
    localparam int AES_BYTES   = 16;
    localparam int AES_COLS    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_state_t;

endpackage

// File: rtl/inv_sbox.sv
// Combinational AES inverse S-box lookup (one byte in, one byte out).
module inv_sbox (
    input  logic [7:0] i_data,
    output logic [7:0] o_data
);

    always_comb begin
        o_data = 8'h00;
        case (i_data)
            8'h00: o_data = 8'h52; 8'h01: o_data = 8'h09; 8'h02: o_data = 8'h6a; 8'h03: o_data = 8'hd5;
            8'h04: o_data = 8'h30; 8'h05: o_data = 8'h36; 8'h06: o_data = 8'ha5; 8'h07: o_data = 8'h38;
            8'h08: o_data = 8'hbf; 8'h09: o_data = 8'h40; 8'h0a: o_data = 8'ha3; 8'h0b: o_data = 8'h9e;
            8'h0c: o_data = 8'h81; 8'h0d: o_data = 8'hf3; 8'h0e: o_data = 8'hd7; 8'h0f: o_data = 8'hfb;
            8'h10: o_data = 8'h7c; 8'h11: o_data = 8'he3; 8'h12: o_data = 8'h39; 8'h13: o_data = 8'h82;
            8'h14: o_data = 8'h9b; 8'h15: o_data = 8'h2f; 8'h16: o_data = 8'hff; 8'h17: o_data = 8'h87;
            8'h18: o_data = 8'h34; 8'h19: o_data = 8'h8e; 8'h1a: o_data = 8'h43; 8'h1b: o_data = 8'h44;
            8'h1c: o_data = 8'hc4; 8'h1d: o_data = 8'hde; 8'h1e: o_data = 8'he9; 8'h1f: o_data = 8'hcb;
            8'h20: o_data = 8'h54; 8'h21: o_data = 8'h7b; 8'h22: o_data = 8'h94; 8'h23: o_data = 8'h32;
            8'h24: o_data = 8'ha6; 8'h25: o_data = 8'hc2; 8'h26: o_data = 8'h23; 8'h27: o_data = 8'h3d;
            8'h28: o_data = 8'hee; 8'h29: o_data = 8'h4c; 8'h2a: o_data = 8'h95; 8'h2b: o_data = 8'h0b;
            8'h2c: o_data = 8'h42; 8'h2d: o_data = 8'hfa; 8'h2e: o_data = 8'hc3; 8'h2f: o_data = 8'h4e;
            8'h30: o_data = 8'h08; 8'h31: o_data = 8'h2e; 8'h32: o_data = 8'ha1; 8'h33: o_data = 8'h66;
            8'h34: o_data = 8'h28; 8'h35: o_data = 8'hd9; 8'h36: o_data = 8'h24; 8'h37: o_data = 8'hb2;
            8'h38: o_data = 8'h76; 8'h39: o_data = 8'h5b; 8'h3a: o_data = 8'ha2; 8'h3b: o_data = 8'h49;
            8'h3c: o_data = 8'h6d; 8'h3d: o_data = 8'h8b; 8'h3e: o_data = 8'hd1; 8'h3f: o_data = 8'h25;
            8'h40: o_data = 8'h72; 8'h41: o_data = 8'hf8; 8'h42: o_data = 8'hf6; 8'h43: o_data = 8'h64;
            8'h44: o_data = 8'h86; 8'h45: o_data = 8'h68; 8'h46: o_data = 8'h98; 8'h47: o_data = 8'h16;
            8'h48: o_data = 8'hd4; 8'h49: o_data = 8'ha4; 8'h4a: o_data = 8'h5c; 8'h4b: o_data = 8'hcc;
            8'h4c: o_data = 8'h5d; 8'h4d: o_data = 8'h65; 8'h4e: o_data = 8'hb6; 8'h4f: o_data = 8'h92;
            8'h50: o_data = 8'h6c; 8'h51: o_data = 8'h70; 8'h52: o_data = 8'h48; 8'h53: o_data = 8'h50;
            8'h54: o_data = 8'hfd; 8'h55: o_data = 8'hed; 8'h56: o_data = 8'hb9; 8'h57: o_data = 8'hda;
            8'h58: o_data = 8'h5e; 8'h59: o_data = 8'h15; 8'h5a: o_data = 8'h46; 8'h5b: o_data = 8'h57;
            8'h5c: o_data = 8'ha7; 8'h5d: o_data = 8'h8d; 8'h5e: o_data = 8'h9d; 8'h5f: o_data = 8'h84;
            8'h60: o_data = 8'h90; 8'h61: o_data = 8'hd8; 8'h62: o_data = 8'hab; 8'h63: o_data = 8'h00;
            8'h64: o_data = 8'h8c; 8'h65: o_data = 8'hbc; 8'h66: o_data = 8'hd3; 8'h67: o_data = 8'h0a;
            8'h68: o_data = 8'hf7; 8'h69: o_data = 8'he4; 8'h6a: o_data = 8'h58; 8'h6b: o_data = 8'h05;
            8'h6c: o_data = 8'hb8; 8'h6d: o_data = 8'hb3; 8'h6e: o_data = 8'h45; 8'h6f: o_data = 8'h06;
            8'h70: o_data = 8'hd0; 8'h71: o_data = 8'h2c; 8'h72: o_data = 8'h1e; 8'h73: o_data = 8'h8f;
            8'h74: o_data = 8'hca; 8'h75: o_data = 8'h3f; 8'h76: o_data = 8'h0f; 8'h77: o_data = 8'h02;
            8'h78: o_data = 8'hc1; 8'h79: o_data = 8'haf; 8'h7a: o_data = 8'hbd; 8'h7b: o_data = 8'h03;
            8'h7c: o_data = 8'h01; 8'h7d: o_data = 8'h13; 8'h7e: o_data = 8'h8a; 8'h7f: o_data = 8'h6b;
            8'h80: o_data = 8'h3a; 8'h81: o_data = 8'h91; 8'h82: o_data = 8'h11; 8'h83: o_data = 8'h41;
            8'h84: o_data = 8'h4f; 8'h85: o_data = 8'h67; 8'h86: o_data = 8'hdc; 8'h87: o_data = 8'hea;
            8'h88: o_data = 8'h97; 8'h89: o_data = 8'hf2; 8'h8a: o_data = 8'hcf; 8'h8b: o_data = 8'hce;
            8'h8c: o_data = 8'hf0; 8'h8d: o_data = 8'hb4; 8'h8e: o_data = 8'he6; 8'h8f: o_data = 8'h73;
            8'h90: o_data = 8'h96; 8'h91: o_data = 8'hac; 8'h92: o_data = 8'h74; 8'h93: o_data = 8'h22;
            8'h94: o_data = 8'he7; 8'h95: o_data = 8'had; 8'h96: o_data = 8'h35; 8'h97: o_data = 8'h85;
            8'h98: o_data = 8'he2; 8'h99: o_data = 8'hf9; 8'h9a: o_data = 8'h37; 8'h9b: o_data = 8'he8;
            8'h9c: o_data = 8'h1c; 8'h9d: o_data = 8'h75; 8'h9e: o_data = 8'hdf; 8'h9f: o_data = 8'h6e;
            8'ha0: o_data = 8'h47; 8'ha1: o_data = 8'hf1; 8'ha2: o_data = 8'h1a; 8'ha3: o_data = 8'h71;
            8'ha4: o_data = 8'h1d; 8'ha5: o_data = 8'h29; 8'ha6: o_data = 8'hc5; 8'ha7: o_data = 8'h89;
            8'ha8: o_data = 8'h6f; 8'ha9: o_data = 8'hb7; 8'haa: o_data = 8'h62; 8'hab: o_data = 8'h0e;
            8'hac: o_data = 8'haa; 8'had: o_data = 8'h18; 8'hae: o_data = 8'hbe; 8'haf: o_data = 8'h1b;
            8'hb0: o_data = 8'hfc; 8'hb1: o_data = 8'h56; 8'hb2: o_data = 8'h3e; 8'hb3: o_data = 8'h4b;
            8'hb4: o_data = 8'hc6; 8'hb5: o_data = 8'hd2; 8'hb6: o_data = 8'h79; 8'hb7: o_data = 8'h20;
            8'hb8: o_data = 8'h9a; 8'hb9: o_data = 8'hdb; 8'hba: o_data = 8'hc0; 8'hbb: o_data = 8'hfe;
            8'hbc: o_data = 8'h78; 8'hbd: o_data = 8'hcd; 8'hbe: o_data = 8'h5a; 8'hbf: o_data = 8'hf4;
            8'hc0: o_data = 8'h1f; 8'hc1: o_data = 8'hdd; 8'hc2: o_data = 8'ha8; 8'hc3: o_data = 8'h33;
            8'hc4: o_data = 8'h88; 8'hc5: o_data = 8'h07; 8'hc6: o_data = 8'hc7; 8'hc7: o_data = 8'h31;
            8'hc8: o_data = 8'hb1; 8'hc9: o_data = 8'h12; 8'hca: o_data = 8'h10; 8'hcb: o_data = 8'h59;
            8'hcc: o_data = 8'h27; 8'hcd: o_data = 8'h80; 8'hce: o_data = 8'hec; 8'hcf: o_data = 8'h5f;
            8'hd0: o_data = 8'h60; 8'hd1: o_data = 8'h51; 8'hd2: o_data = 8'h7f; 8'hd3: o_data = 8'ha9;
            8'hd4: o_data = 8'h19; 8'hd5: o_data = 8'hb5; 8'hd6: o_data = 8'h4a; 8'hd7: o_data = 8'h0d;
            8'hd8: o_data = 8'h2d; 8'hd9: o_data = 8'he5; 8'hda: o_data = 8'h7a; 8'hdb: o_data = 8'h9f;
            8'hdc: o_data = 8'h93; 8'hdd: o_data = 8'hc9; 8'hde: o_data = 8'h9c; 8'hdf: o_data = 8'hef;
            8'he0: o_data = 8'ha0; 8'he1: o_data = 8'he0; 8'he2: o_data = 8'h3b; 8'he3: o_data = 8'h4d;
            8'he4: o_data = 8'hae; 8'he5: o_data = 8'h2a; 8'he6: o_data = 8'hf5; 8'he7: o_data = 8'hb0;
            8'he8: o_data = 8'hc8; 8'he9: o_data = 8'heb; 8'hea: o_data = 8'hbb; 8'heb: o_data = 8'h3c;
            8'hec: o_data = 8'h83; 8'hed: o_data = 8'h53; 8'hee: o_data = 8'h99; 8'hef: o_data = 8'h61;
            8'hf0: o_data = 8'h17; 8'hf1: o_data = 8'h2b; 8'hf2: o_data = 8'h04; 8'hf3: o_data = 8'h7e;
            8'hf4: o_data = 8'hba; 8'hf5: o_data = 8'h77; 8'hf6: o_data = 8'hd6; 8'hf7: o_data = 8'h26;
            8'hf8: o_data = 8'he1; 8'hf9: o_data = 8'h69; 8'hfa: o_data = 8'h14; 8'hfb: o_data = 8'h63;
            8'hfc: o_data = 8'h55; 8'hfd: o_data = 8'h21; 8'hfe: o_data = 8'h0c; 8'hff: o_data = 8'h7d;
            default: o_data = 8'h00;
        endcase
    end

endmodule

// File: rtl/inv_sub_byte.sv
// AES InvSubBytes over a 128-bit state with an IDLE/RUN/DONE valid-ready handshake.
// Define INV_SUB_BYTE_FULL_PARALLEL_EN for a 16-lookup single-pass datapath; default is column-serial.
module inv_sub_byte
    import aes_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   bypass,
    input  logic [AES_STATE_W-1:0] state_in,
    output logic                   in_ready,
    output logic                   busy,
    output logic [AES_STATE_W-1:0] state_out,
    output logic                   out_valid,
    input  logic                   out_ready
);

    fsm_state_t             r_state;
    logic [1:0]             r_cnt;
    logic [AES_STATE_W-1:0] r_work;
    logic [AES_STATE_W-1:0] r_out;

    logic [AES_STATE_W-1:0] w_work_next;
    logic                   w_last;

    genvar gi;

`ifdef INV_SUB_BYTE_FULL_PARALLEL_EN
    // Every byte substituted in the single RUN cycle.
    assign w_last = 1'b1;

    generate
        for (gi = 0; gi < AES_BYTES; gi++) begin : g_sbox
            inv_sbox u_inv_sbox (
                .i_data (r_work[AES_STATE_W-1-8*gi -: 8]),
                .o_data (w_work_next[AES_STATE_W-1-8*gi -: 8])
            );
        end
    endgenerate
`else
    logic [31:0] w_col_in;
    logic [31:0] w_col_sub;

    assign w_last = (r_cnt == 2'd3);

    always_comb begin
        w_col_in = 32'h0;
        case (r_cnt)
            2'd0:    w_col_in = r_work[127:96];
            2'd1:    w_col_in = r_work[95:64];
            2'd2:    w_col_in = r_work[63:32];
            default: w_col_in = r_work[31:0];
        endcase
    end

    generate
        for (gi = 0; gi < 4; gi++) begin : g_sbox
            inv_sbox u_inv_sbox (
                .i_data (w_col_in[31-8*gi -: 8]),
                .o_data (w_col_sub[31-8*gi -: 8])
            );
        end

        // Only the column selected by the counter changes; the rest pass through.
        for (gi = 0; gi < AES_COLS; gi++) begin : g_col
            assign w_work_next[AES_STATE_W-1-32*gi -: 32] =
                (r_cnt == 2'(gi)) ? w_col_sub : r_work[AES_STATE_W-1-32*gi -: 32];
        end
    endgenerate
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= 2'd0;
            r_work  <= '0;
            r_out   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (bypass) begin
                            r_out   <= state_in;
                            r_state <= DONE;
                        end else begin
                            r_work  <= state_in;
                            r_cnt   <= 2'd0;
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    r_work <= w_work_next;
                    r_cnt  <= r_cnt + 2'd1;
                    if (w_last) begin
                        r_out   <= w_work_next;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state == RUN);
    assign out_valid = (r_state == DONE);
    assign state_out = r_out;

endmodule

// File: doc/inv_sub_byte.md
INV_SUB_BYTE -- requirements
Module: inv_sub_byte

Interface
REQ-001 SHALL have no parameters; the datapath width is fixed at 128 bits.
REQ-002 clk  input  1  clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request; accepted only when in_ready=1.
REQ-005 bypass  input  1  sampled with an accepted start; 1 = pass the state through unsubstituted.
REQ-006 state_in  input  128  cipher state; byte 0 at [127:120], byte 15 at [7:0], column k = bytes 4k..4k+3.
REQ-007 in_ready  output  1  high only in IDLE.
REQ-008 busy  output  1  high in RUN.
REQ-009 state_out  output  128  InvSubBytes result, same byte order as state_in.
REQ-010 out_valid  output  1  high only in DONE.
REQ-011 out_ready  input  1  downstream accepts state_out.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-013 IDLE: at an edge with start=1 and bypass=0, SHALL capture state_in into a working register, clear the 2-bit column counter, and enter RUN.
REQ-014 IDLE: at an edge with start=1 and bypass=1, SHALL load state_in unchanged into state_out and enter DONE, so out_valid is high one cycle after acceptance.
REQ-015 RUN: at each edge, SHALL replace the 4 bytes of column[counter] with their inverse S-box values and increment the counter.
REQ-016 RUN: the edge that processes column 3 SHALL also load the finished state into state_out and enter DONE, giving 4 edges from acceptance to out_valid.
REQ-017 Bytes outside the current column SHALL be unchanged in every RUN cycle.
REQ-018 DONE: state_out and out_valid SHALL hold stable until an edge with out_ready=1, which returns the FSM to IDLE.
REQ-019 in_ready SHALL be high again one cycle after that transfer; same-cycle accept-and-transfer SHALL NOT occur.
REQ-020 start asserted outside IDLE SHALL be ignored, with no queuing.
REQ-021 bypass outside an accepting edge SHALL have no effect.
REQ-022 state_in SHALL be sampled only at the accepting edge; later changes SHALL NOT affect the result.
REQ-023 The counter SHALL wrap 3->0 and SHALL be don't-care outside RUN.
REQ-024 Inverse S-box values SHALL match the FIPS-197 inverse table bit-exactly.

Reset
REQ-025 While rst=0: FSM=IDLE, counter=0, working register=0, state_out=0, out_valid=0, busy=0, in_ready=1.
REQ-026 Reset asserted mid-RUN or mid-DONE SHALL abort the operation immediately to the REQ-025 values; no partial result SHALL be presented.

Configuration
REQ-027 Macro INV_SUB_BYTE_FULL_PARALLEL_EN SHALL select the datapath.
REQ-028 With the macro defined: 16 inv_sbox instances; RUN lasts one edge, all 16 bytes are substituted at once, and out_valid is high 1 edge after acceptance.
REQ-029 With the macro undefined: 4 inv_sbox instances shared across the columns, with 4-edge latency per REQ-016.
REQ-030 Bypass, handshake, and reset behaviour SHALL be identical in both builds.

Structure
REQ-031 Package aes_pkg SHALL hold the FSM state enum (IDLE/RUN/DONE), AES_STATE_W=128, AES_BYTES=16, and AES_COLS=4.
REQ-032 Sub-module inv_sbox SHALL be purely combinational: 8-bit in, 8-bit out, 256-entry case table.
REQ-033 inv_sub_byte SHALL instantiate inv_sbox and hold only the FSM, counter, and registers.

Verification
REQ-034 Reset: hold rst=0 for 3 cycles -> state_out=0, out_valid=0, in_ready=1; release, no start -> unchanged.
REQ-035 Basic: state_in all bytes 0x63, start, out_ready=1 -> out_valid on edge 4 (edge 1 in parallel build), state_out all 0x00.
REQ-036 Per-byte: state_in bytes 0x00,0x7C,0xED,0x16 repeated -> output bytes 0x52,0x01,0x53,0xFF repeated, in the correct byte positions.
REQ-037 Bypass: state_in=0x00112233_44556677_8899AABB_CCDDEEFF with bypass=1 -> out_valid after 1 edge, identical state_out.
REQ-038 Backpressure and ignore: out_ready=0 for 5 cycles with start and a changing state_in pulsed during RUN/DONE -> state_out stable and out_valid high throughout; a single transfer occurs once out_ready=1.
REQ-039 Abort: pull rst low at RUN counter=2 -> outputs match REQ-025; a fresh start afterwards yields a correct result.
